uart_tx_fifo: RTL

Buffered UART transmitter: accepts bytes on a parallel bus with a single-cycle write strobe, holds them in an 8-entry FIFO, and serializes them 8N1, LSB first, on `TX`. It is the transmit-side counterpart to the receive path. It sits between any byte producer and the board TX pin, so the producer can burst several bytes without waiting on the line.

---
 rtl/uart_pkg.sv | 13 +
 rtl/byte_fifo.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
package uart_pkg;
  localparam int UART_DATA_W          = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous show-ahead byte FIFO; count is the pointer difference
// using one extra pointer MSB to tell full from empty.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   push;
  logic                   pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1 LSB first.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity between bit 7 and stop).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); pops the next byte directly if one is queued
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [UART_DATA_W-1:0]      data_bus,
  input  logic                        write_enable,
  output logic                        TC,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        TX
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  tx_state_t              state;
  logic [BW-1:0]          baud;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shift;
  logic [UART_DATA_W-1:0] head;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic                   parity;
`endif

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (write_enable),
    .wr_data (data_bus),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign TC        = ~full;
  assign baud_wrap = (baud == BAUD_LAST);
  assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_wrap));
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TX      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      baud <= (state == IDLE || baud_wrap) ? '0 : baud + BAUD_ONE;
      case (state)
        IDLE: begin
          TX <= 1'b1;
          if (pop) begin
            shift   <= head;
            bit_idx <= '0;
            state   <= START;
            TX      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= ^head;
`endif
          end
        end
        START: begin
          if (baud_wrap) begin
            state <= DATA;
            TX    <= shift[0];
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              TX    <= parity;
`else
              state <= STOP;
              TX    <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              TX      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_wrap) begin
            state <= STOP;
            TX    <= 1'b1;
          end
        end
`endif
        STOP: begin
          // Chaining straight into START keeps back-to-back frames gap-free.
          if (baud_wrap) begin
            if (pop) begin
              shift   <= head;
              bit_idx <= '0;
              state   <= START;
              TX      <= 1'b0;
`ifdef UART_TX_PARITY_EN
              parity  <= ^head;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          TX    <= 1'b1;
        end
      endcase
    end
  end
endmodule
